// File: rtl/fabric_config_loader.sv
// Loads the fabric config scan chain LSB-first from a valid/ready word stream, then strobes the latch.
// Optional CRC-8 check of the shifted stream before latching: define CONFIG_CRC_EN.
module fabric_config_loader #(
    parameter int CHAIN_LENGTH = 20,
    parameter int WORD_WIDTH   = 8,
    parameter int SHIFT_DIV    = 1
) (
    input  logic                                  i_Clock,
    input  logic                                  i_Reset_n,
    input  logic                                  i_Start,
    input  logic [WORD_WIDTH-1:0]                 i_Data,
    input  logic                                  i_Valid,
    output logic                                  o_Ready,
    output logic                                  o_ConfigData,
    output logic                                  o_ConfigClockEnable,
    output logic                                  o_ConfigLatch,
    output logic                                  o_Busy,
    output logic                                  o_Done,
    output logic                                  o_Error,
    output logic [$clog2(CHAIN_LENGTH+1)-1:0]     o_BitCount
);

    localparam int CW  = $clog2(CHAIN_LENGTH + 1);
    localparam int WBW = $clog2(WORD_WIDTH);
    localparam int DW  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

    localparam logic [CW-1:0]  LAST_BIT  = CW'(CHAIN_LENGTH - 1);
    localparam logic [WBW-1:0] WORD_LAST = WBW'(WORD_WIDTH - 1);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(SHIFT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_LATCH,
        S_DONE
`ifdef CONFIG_CRC_EN
        ,
        S_WAIT_CRC,
        S_ERROR
`endif
    } state_t;

    state_t               state, state_next;
    logic [1:0]           rst_sync;
    logic                 rst_n;
    logic [WORD_WIDTH-1:0] word;
    logic [WBW-1:0]       word_bits;
    logic [DW-1:0]        div_cnt;
    logic [CW-1:0]        bit_count;
    logic                 shift_tick;
    logic                 load_start;
    logic                 accept;
`ifdef CONFIG_CRC_EN
    logic [7:0]           crc;
    logic                 crc_fb;
`endif

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign shift_tick = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    assign accept     = (state == S_WAIT_WORD) && i_Valid;

    always_comb begin
        load_start = 1'b0;
        case (state)
            S_IDLE, S_DONE: load_start = i_Start;
`ifdef CONFIG_CRC_EN
            S_ERROR:        load_start = i_Start;
`endif
            default:        load_start = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (i_Start) state_next = S_WAIT_WORD;
            S_WAIT_WORD:    if (i_Valid) state_next = S_SHIFT;
            S_SHIFT: begin
                if (shift_tick) begin
                    if (bit_count == LAST_BIT)
`ifdef CONFIG_CRC_EN
                        state_next = S_WAIT_CRC;
`else
                        state_next = S_LATCH;
`endif
                    else if (word_bits == WORD_LAST)
                        state_next = S_WAIT_WORD;
                end
            end
            S_LATCH:        state_next = S_DONE;
`ifdef CONFIG_CRC_EN
            S_WAIT_CRC:     if (i_Valid) state_next = (i_Data[7:0] == crc) ? S_LATCH : S_ERROR;
            S_ERROR:        if (i_Start) state_next = S_WAIT_WORD;
`endif
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Ready             = (state == S_WAIT_WORD);
        o_ConfigClockEnable = shift_tick;
        o_ConfigData        = shift_tick & word[0];
        o_ConfigLatch       = (state == S_LATCH);
        o_Busy              = (state == S_WAIT_WORD) || (state == S_SHIFT) || (state == S_LATCH);
        o_Done              = (state == S_DONE);
        o_Error             = 1'b0;
`ifdef CONFIG_CRC_EN
        if (state == S_WAIT_CRC) begin
            o_Ready = 1'b1;
            o_Busy  = 1'b1;
        end
        o_Error = (state == S_ERROR);
`endif
    end

    assign o_BitCount = bit_count;

    // NOTE: the word register is a plain shift register, so it is reset along with the counters.
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            word_bits <= '0;
            div_cnt   <= '0;
            bit_count <= '0;
        end else begin
            if (load_start) bit_count <= '0;
            if (accept) begin
                word      <= i_Data;
                word_bits <= '0;
            end
            if (state == S_SHIFT) begin
                if (shift_tick) begin
                    div_cnt   <= '0;
                    word      <= word >> 1;
                    word_bits <= word_bits + WBW'(1);
                    bit_count <= bit_count + CW'(1);
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end else begin
                div_cnt <= '0;
            end
        end
    end

`ifdef CONFIG_CRC_EN
    // CRC-8 (x^8+x^2+x+1) advanced once per emitted chain bit.
    assign crc_fb = crc[7] ^ word[0];

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n)
            crc <= 8'h00;
        else if (load_start)
            crc <= 8'h00;
        else if (shift_tick)
            crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader: lane 0 runs SHIFT_DIV=1, lane 1 runs SHIFT_DIV=3.
// A spec-level model (expected bit stream per load) is compared against both lanes every cycle.
module tb_fabric_config_loader;

    localparam int CL = 20;
    localparam int WW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       valid;
    logic [7:0] data;
    int         sel;

    logic       rdy  [2];
    logic       cd   [2];
    logic       ce   [2];
    logic       lat  [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];
    logic [4:0] bc   [2];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses   [2];
    int         latches  [2];
    int         last_cyc [2];
    int         div_of   [2];
    logic [CL-1:0] stream [2];
    bit         exp_q0 [$];
    bit         exp_q1 [$];

    always #5 clk = ~clk;

    fabric_config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .SHIFT_DIV(1)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Start(start && sel == 0), .i_Data(data), .i_Valid(valid && sel == 0),
        .o_Ready(rdy[0]), .o_ConfigData(cd[0]), .o_ConfigClockEnable(ce[0]),
        .o_ConfigLatch(lat[0]), .o_Busy(busy[0]), .o_Done(done[0]),
        .o_Error(err[0]), .o_BitCount(bc[0])
    );

    fabric_config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .SHIFT_DIV(3)) dut_div3 (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Start(start && sel == 1), .i_Data(data), .i_Valid(valid && sel == 1),
        .o_Ready(rdy[1]), .o_ConfigData(cd[1]), .o_ConfigClockEnable(ce[1]),
        .o_ConfigLatch(lat[1]), .o_Busy(busy[1]), .o_Done(done[1]),
        .o_Error(err[1]), .o_BitCount(bc[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_size(input int l);
        return (l == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic bit q_pop(input int l);
        return (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    task automatic lane_cmp(input int l);
        bit exp_bit;
        if (busy[l]) check("bit_count", bc[l], pulses[l]);
        if (!ce[l]) check("data_zero_when_idle", cd[l], 0);
        if (ce[l]) begin
            check("enable_only_when_busy", busy[l], 1);
            check("pulse_within_chain", (q_size(l) > 0), 1);
            if (q_size(l) > 0) begin
                exp_bit = q_pop(l);
                check("config_bit", cd[l], exp_bit);
            end
            if (pulses[l] < CL) stream[l][pulses[l]] = cd[l];
            if (pulses[l] % WW != 0) check("pulse_spacing", cyc - last_cyc[l], div_of[l]);
            last_cyc[l] = cyc;
            pulses[l]++;
        end
        if (lat[l]) begin
            latches[l]++;
            check("latch_after_full_chain", pulses[l], CL);
            check("latch_stream_consumed", q_size(l), 0);
        end
`ifndef CONFIG_CRC_EN
        check("error_tied_low", err[l], 0);
`endif
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int l = 0; l < 2; l++) lane_cmp(l);
    end

    task automatic check_all_zero(input int l, input string tag);
        check({tag, "_ready"}, rdy[l], 0);
        check({tag, "_cdata"}, cd[l], 0);
        check({tag, "_cen"},   ce[l], 0);
        check({tag, "_latch"}, lat[l], 0);
        check({tag, "_busy"},  busy[l], 0);
        check({tag, "_done"},  done[l], 0);
        check({tag, "_error"}, err[l], 0);
        check({tag, "_bitcnt"}, bc[l], 0);
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        int t = 0;
        int p0;
        @(negedge clk);
        while (!rdy[sel] && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait_bounded", (t < 500), 1);
        p0 = pulses[sel];
        repeat (gap) begin
            check("ready_held_in_gap", rdy[sel], 1);
            @(negedge clk);
        end
        check("no_pulse_in_gap", pulses[sel], p0);
        data  = w;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic logic [7:0] crc8(input logic [CL-1:0] bits);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < CL; i++) begin
            if (c[7] ^ bits[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Sets up the expected stream for one load and primes the lane's model state.
    task automatic prime_model(input int l, input logic [7:0] w0, w1, w2, output logic [CL-1:0] exp_vec);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        if (l == 0) exp_q0.delete(); else exp_q1.delete();
        for (int i = 0; i < CL; i++) begin
            exp_vec[i] = w[i / WW][i % WW];
            if (l == 0) exp_q0.push_back(exp_vec[i]); else exp_q1.push_back(exp_vec[i]);
        end
        pulses[l] = 0;
        stream[l] = '0;
        sel = l;
    endtask

    task automatic do_load(input int l, input logic [7:0] w0, w1, w2, input int gap,
                           input bit junk, input logic [7:0] crc_xor, input bit expect_ok);
        logic [CL-1:0] exp_vec;
        int lat0;
        int t = 0;
        prime_model(l, w0, w1, w2, exp_vec);
        lat0 = latches[l];
        pulse_start();
        send_word(w0, 0);
        if (junk) begin
            start = 1'b1;
            valid = 1'b1;
            data  = 8'hFF;
            @(posedge clk);
            @(posedge clk);
            #1 start = 1'b0;
            valid = 1'b0;
        end
        send_word(w1, gap);
        send_word(w2, gap);
`ifdef CONFIG_CRC_EN
        send_word(crc8(exp_vec) ^ crc_xor, 0);
`else
        if (crc_xor != 8'h00) check("crc_word_unused", crc8(exp_vec) ^ crc_xor, crc8(exp_vec));
`endif
        do begin
            @(negedge clk);
            #1 t++;
        end while (!(done[l] || err[l]) && t < 500);
        check("load_finish_bounded", (t < 500), 1);
        if (expect_ok) begin
            check("done_after_load", done[l], 1);
            check("bitcount_in_done", bc[l], CL);
            check("single_latch", latches[l] - lat0, 1);
            check("pulse_total", pulses[l], CL);
            check("model_stream", stream[l], exp_vec);
        end else begin
            check("error_on_bad_crc", err[l], 1);
            check("no_done_on_bad_crc", done[l], 0);
            check("no_latch_on_bad_crc", latches[l] - lat0, 0);
        end
    endtask

    initial begin
        logic [CL-1:0] scratch;
        int t;
        int lat0;
        for (int l = 0; l < 2; l++) begin
            pulses[l] = 0; latches[l] = 0; last_cyc[l] = 0; stream[l] = '0;
        end
        div_of[0] = 1;
        div_of[1] = 3;
        sel   = 0;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        rst_n = 1'b0;
        #12;
        check_all_zero(0, "reset_a");
        check_all_zero(1, "reset_b");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Basic load; stream pinned to hand-computed bit order.
        do_load(0, 8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 8'h00, 1'b1);
        check("basic_stream_literal", stream[0], 20'hF3CA5);

        // Backpressure: 5 idle cycles before the second and third words.
        do_load(0, 8'hA5, 8'h3C, 8'h0F, 5, 1'b0, 8'h00, 1'b1);
        check("backpressure_stream_literal", stream[0], 20'hF3CA5);

        // Start/valid junk mid-SHIFT, restarting from DONE.
        do_load(0, 8'hA5, 8'h3C, 8'h0F, 0, 1'b1, 8'h00, 1'b1);
        check("ignored_inputs_stream_literal", stream[0], 20'hF3CA5);

        // Different pattern: upper nibble of last word must be discarded.
        do_load(0, 8'h01, 8'h80, 8'hFE, 0, 1'b0, 8'h00, 1'b1);
        check("partial_word_stream_literal", stream[0], 20'hE8001);

        // Divided shift clock on the second instance.
        do_load(1, 8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 8'h00, 1'b1);
        check("div3_stream_literal", stream[1], 20'hF3CA5);

        // Reset after 10 bits: outputs drop at once and no latch follows.
        prime_model(0, 8'hA5, 8'h3C, 8'h0F, scratch);
        lat0 = latches[0];
        pulse_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        t = 0;
        do begin
            @(negedge clk);
            #1 t++;
        end while (pulses[0] < 10 && t < 200);
        check("reach_10_bits_bounded", (t < 200), 1);
        check("busy_before_abort", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero(0, "abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("no_latch_after_abort", latches[0] - lat0, 0);
        do_load(0, 8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 8'h00, 1'b1);
        check("post_abort_stream_literal", stream[0], 20'hF3CA5);

`ifdef CONFIG_CRC_EN
        check("crc_of_zero_stream", crc8('0), 8'h00);
        do_load(0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b1);
        do_load(0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h01, 1'b0);
        pulses[0] = 0;
        pulse_start();
        @(negedge clk);
        #1;
        check("start_clears_error", err[0], 0);
        check("restart_after_error_ready", rdy[0], 1);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
Sequences configuration of the fabric's serial config scan chain, which holds LUT bits, FF enables and constant-drive cells for a mapped design.
- Accepts configuration words from an upstream bitstream source over a valid/ready handshake.
- Shifts each word into the chain LSB-first, one bit per shift tick.
- Pulses a latch strobe once the full chain is loaded, transferring shadow config to active.
- Sits between the bitstream source (host/SPI reader) and the fabric config chain.

Parameters:
CHAIN_LENGTH, 20, total config bits in the scan chain (>=1)
WORD_WIDTH, 8, bits per input config word (>=8)
SHIFT_DIV, 1, clock cycles per shifted bit (>=1); o_ConfigClockEnable pulses once every SHIFT_DIV cycles

Ports:
i_Clock  input  1  system clock, all logic on posedge
i_Reset_n  input  1  asynchronous active-low reset
i_Start  input  1  begin a load; sampled only in IDLE or DONE (or ERROR with CRC)
i_Data  input  WORD_WIDTH  config word
i_Valid  input  1  i_Data valid
o_Ready  output  1  loader accepts a word this cycle
o_ConfigData  output  1  serial bit to the chain, valid when o_ConfigClockEnable=1
o_ConfigClockEnable  output  1  chain shift enable, one cycle per bit
o_ConfigLatch  output  1  one-cycle strobe: chain fully loaded
o_Busy  output  1  high in any state except IDLE/DONE/ERROR
o_Done  output  1  high in DONE
o_Error  output  1  CRC mismatch (CONFIG_CRC_EN only, else tied 0)
o_BitCount  output  $clog2(CHAIN_LENGTH+1)  bits shifted so far this load

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE. All outputs 0, including o_BitCount. Word register, divider and CRC cleared.
- Reset mid-load: aborts immediately and never emits o_ConfigLatch. Chain contents are undefined; software reloads.
- IDLE: i_Start=1 -> WAIT_WORD next cycle, o_BitCount cleared.
- WAIT_WORD: o_Ready=1 (combinational from state only, never from i_Valid).
  - i_Valid&o_Ready -> capture i_Data, go to SHIFT.
  - i_Valid low -> wait indefinitely; no timeout.
- SHIFT: divider counts 0..SHIFT_DIV-1. On terminal count:
  - o_ConfigClockEnable=1 and o_ConfigData=word[0]; word shifts right; o_BitCount+1.
  - First bit emitted in the first SHIFT cycle when SHIFT_DIV=1.
- Leaving SHIFT (evaluated after each emitted bit):
  - Last bit of the chain emitted (o_BitCount reaches CHAIN_LENGTH) -> LATCH. Remaining upper bits of a partial final word are discarded.
  - Otherwise, all WORD_WIDTH bits of the word emitted -> WAIT_WORD.
- LATCH: o_ConfigLatch=1 for exactly one cycle -> DONE.
- DONE: o_Done=1, o_BitCount holds CHAIN_LENGTH. i_Start=1 -> WAIT_WORD (reload) and clears o_Done.
- i_Start in WAIT_WORD/SHIFT/LATCH: ignored.
- i_Valid outside WAIT_WORD: ignored, no capture.
- Minimum per-word cost: WORD_WIDTH*SHIFT_DIV shift cycles + 1 WAIT_WORD cycle.
- o_ConfigClockEnable never high outside SHIFT. o_ConfigData=0 whenever enable=0.

Optional Feature:
CONFIG_CRC_EN.
- Defined:
  - CRC-8, poly 0x07, init 0x00, updated bitwise over each emitted o_ConfigData bit in shift order.
  - After the last chain bit, go to WAIT_CRC instead of LATCH. o_Ready=1 and one word is accepted; i_Data[7:0] is compared to the CRC.
  - Match -> LATCH.
  - Mismatch -> ERROR: o_Error=1, no latch, o_Done=0. i_Start clears o_Error and goes to WAIT_WORD.
- Not defined: no CRC logic, no WAIT_CRC/ERROR states, o_Error constant 0.

Test Plan:
- Test defaults: CHAIN_LENGTH=20, WORD_WIDTH=8, SHIFT_DIV=1.
- Basic load: start, words 0xA5,0x3C,0x0F.
  - o_ConfigData on enable cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1 (20 pulses).
  - One o_ConfigLatch, then o_Done=1, o_BitCount=20.
- Backpressure: i_Valid low 5 cycles between words -> no enable pulses while waiting. Data order unchanged. o_Ready high the whole gap.
- SHIFT_DIV=3: same words -> enable pulses exactly 3 cycles apart within a word. Total 20 pulses, single latch.
- Ignored inputs: i_Start and i_Valid pulsed mid-SHIFT -> no extra capture, bit stream identical. Restart from DONE reloads cleanly.
- Reset mid-load: assert i_Reset_n=0 after 10 bits -> all outputs 0 asynchronously, no latch. After release, a full load succeeds.
- CONFIG_CRC_EN (data 0x00,0x00,0x00):
  - CRC word 0x00 -> latch, o_Done=1.
  - CRC word 0x01 -> o_Error=1, no latch. i_Start then clears o_Error.
